// File: rtl/imem_program_loader.sv
// Encodes host instruction-field bundles into 32-bit words and streams them into
// instruction memory via a small FIFO; holds cpu_rst until the last word lands.

`ifndef OP_CODE_LEN
`define OP_CODE_LEN 6
`endif
`ifndef REG_FILE_ADDR_LEN
`define REG_FILE_ADDR_LEN 5
`endif
`ifndef WORD_LEN
`define WORD_LEN 32
`endif
`ifndef OP_NOP
`define OP_NOP  6'd0
`define OP_ADD  6'd1
`define OP_SUB  6'd2
`define OP_SLA  6'd3
`define OP_SRA  6'd4
`define OP_AND  6'd5
`define OP_OR   6'd6
`define OP_NOR  6'd7
`define OP_XOR  6'd8
`define OP_SLL  6'd9
`define OP_SRL  6'd10
`define OP_ADDI 6'd11
`define OP_SUBI 6'd12
`define OP_LD   6'd13
`define OP_ST   6'd14
`define OP_BEZ  6'd15
`define OP_BNE  6'd16
`define OP_JMP  6'd17
`endif

// Generic synchronous FIFO with flush; head is a registered-array read.
// Push is ignored when full, pop ignored when empty; flush wins over both.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_dat
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_vld && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_dat;
  end

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head_dat = mem[rd_ptr[PW-1:0]];
endmodule

// Loader top: accept -> FIFO -> memory write, 1-cycle latency, 1 word/cycle.
// in_ready drops when the FIFO is full, after the last bundle, or on start.
module imem_program_loader #(
  parameter int DEPTH    = 4,
  parameter int ADDR_LEN = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [`OP_CODE_LEN-1:0]       in_opcode,
  input  logic [`REG_FILE_ADDR_LEN-1:0] in_dest,
  input  logic [`REG_FILE_ADDR_LEN-1:0] in_src1,
  input  logic [`REG_FILE_ADDR_LEN-1:0] in_src2,
  input  logic [15:0]                   in_imm,
  input  logic                          in_last,
  output logic                          imem_wr_en,
  input  logic                          imem_wr_ready,
  output logic [ADDR_LEN-1:0]           imem_wr_addr,
  output logic [`WORD_LEN-1:0]          imem_wr_data,
  output logic                          cpu_rst,
  output logic                          load_done,
  output logic                          bad_op,
  output logic                          overflow,
  output logic [ADDR_LEN:0]             word_count
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_LEN-1:0]   addr_q;
  logic [ADDR_LEN:0]     word_count_q;
  logic                  bad_op_q;
  logic                  overflow_q;
  logic                  last_seen_q;

  logic                  accept;
  logic                  wr_fire;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [`WORD_LEN:0]    head_dat;
  logic [`WORD_LEN-1:0]  enc_word;
  logic                  enc_bad;

  assign in_ready = (state_q == LOAD) && !fifo_full && !start && !last_seen_q;
  assign accept   = in_valid && in_ready;
  assign wr_fire  = imem_wr_en && imem_wr_ready;

  always_comb begin
    enc_word = {`OP_NOP, 26'b0};
    enc_bad  = 1'b0;
    case (in_opcode)
      `OP_ADD, `OP_SUB, `OP_SLA, `OP_SRA, `OP_AND,
      `OP_OR, `OP_NOR, `OP_XOR, `OP_SLL, `OP_SRL:
        enc_word = {in_opcode, in_dest, in_src1, in_src2, 11'b0};
      // For stores the dest field carries the store-value register.
      `OP_ADDI, `OP_SUBI, `OP_LD, `OP_ST, `OP_BEZ, `OP_BNE, `OP_JMP:
        enc_word = {in_opcode, in_dest, in_src1, in_imm};
      `OP_NOP:
        enc_word = {`OP_NOP, 26'b0};
      default:
        enc_bad  = 1'b1;
    endcase
  end

  sync_fifo #(.WIDTH(`WORD_LEN + 1), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (start),
    .push_vld (accept),
    .push_dat ({in_last, enc_word}),
    .pop      (wr_fire),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_dat (head_dat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start)
      state_d = LOAD;
    else if (state_q == LOAD && wr_fire && head_dat[`WORD_LEN])
      state_d = DONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q       <= '0;
      word_count_q <= '0;
      bad_op_q     <= 1'b0;
      overflow_q   <= 1'b0;
      last_seen_q  <= 1'b0;
    end else if (start) begin
      addr_q       <= '0;
      word_count_q <= '0;
      bad_op_q     <= 1'b0;
      overflow_q   <= 1'b0;
      last_seen_q  <= 1'b0;
    end else begin
      if (accept && enc_bad) bad_op_q    <= 1'b1;
      if (accept && in_last) last_seen_q <= 1'b1;
      if (wr_fire) begin
        addr_q       <= addr_q + ADDR_LEN'(1);
        word_count_q <= word_count_q + (ADDR_LEN+1)'(1);
        if (&addr_q) overflow_q <= 1'b1;
      end
    end
  end

  assign imem_wr_en   = (state_q == LOAD) && !fifo_empty;
  assign imem_wr_data = fifo_empty ? '0 : head_dat[`WORD_LEN-1:0];
  assign imem_wr_addr = addr_q;
  assign cpu_rst      = (state_q != DONE);
  assign load_done    = (state_q == DONE);
  assign bad_op       = bad_op_q;
  assign overflow     = overflow_q;
  assign word_count   = word_count_q;
endmodule

// File: tb/tb_imem_program_loader.sv
// Scoreboard bench: two loader instances (10-bit and 2-bit address) share stimulus.
`ifndef OP_NOP
`define OP_NOP  6'd0
`define OP_ADD  6'd1
`define OP_SUB  6'd2
`define OP_SLA  6'd3
`define OP_SRA  6'd4
`define OP_AND  6'd5
`define OP_OR   6'd6
`define OP_NOR  6'd7
`define OP_XOR  6'd8
`define OP_SLL  6'd9
`define OP_SRL  6'd10
`define OP_ADDI 6'd11
`define OP_SUBI 6'd12
`define OP_LD   6'd13
`define OP_ST   6'd14
`define OP_BEZ  6'd15
`define OP_BNE  6'd16
`define OP_JMP  6'd17
`endif

module tb_imem_program_loader;
  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_last, imem_wr_ready;
  logic [5:0]  in_opcode;
  logic [4:0]  in_dest, in_src1, in_src2;
  logic [15:0] in_imm;

  logic        in_ready, wr_en, cpu_rst, load_done, bad_op, overflow;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic [10:0] word_count;

  logic        w_in_ready, w_wr_en, w_cpu_rst, w_load_done, w_bad_op, w_overflow;
  logic [1:0]  w_wr_addr;
  logic [31:0] w_wr_data;
  logic [2:0]  w_word_count;

  imem_program_loader #(.DEPTH(4), .ADDR_LEN(10)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_dest(in_dest), .in_src1(in_src1), .in_src2(in_src2),
    .in_imm(in_imm), .in_last(in_last), .imem_wr_en(wr_en), .imem_wr_ready(imem_wr_ready),
    .imem_wr_addr(wr_addr), .imem_wr_data(wr_data), .cpu_rst(cpu_rst),
    .load_done(load_done), .bad_op(bad_op), .overflow(overflow), .word_count(word_count)
  );

  imem_program_loader #(.DEPTH(4), .ADDR_LEN(2)) dut_w (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_opcode(in_opcode), .in_dest(in_dest), .in_src1(in_src1), .in_src2(in_src2),
    .in_imm(in_imm), .in_last(in_last), .imem_wr_en(w_wr_en), .imem_wr_ready(imem_wr_ready),
    .imem_wr_addr(w_wr_addr), .imem_wr_data(w_wr_data), .cpu_rst(w_cpu_rst),
    .load_done(w_load_done), .bad_op(w_bad_op), .overflow(w_overflow),
    .word_count(w_word_count)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_addr = 0;
  int          n_writes = 0;
  int          n_acc = 0;
  int          w0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [5:0] op, input logic [4:0] d,
                                        input logic [4:0] s1, input logic [4:0] s2,
                                        input logic [15:0] imm);
    if (op inside {`OP_ADD, `OP_SUB, `OP_SLA, `OP_SRA, `OP_AND,
                   `OP_OR, `OP_NOR, `OP_XOR, `OP_SLL, `OP_SRL})
      return {op, d, s1, s2, 11'd0};
    if (op inside {`OP_ADDI, `OP_SUBI, `OP_LD, `OP_ST, `OP_BEZ, `OP_BNE, `OP_JMP})
      return {op, d, s1, imm};
    return 32'd0;
  endfunction

  // Write monitor: every completed write must match the scoreboard head.
  always @(negedge clk) begin
    if (rst && wr_en && imem_wr_ready) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_data", wr_data, mon_e);
        check("w_wr_data", w_wr_data, mon_e);
      end
      check("wr_addr", wr_addr, exp_addr[9:0]);
      check("w_wr_addr", w_wr_addr, exp_addr[1:0]);
      exp_addr++;
    end
  end

  task automatic send(input logic [5:0] op, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [15:0] imm, input logic last);
    bit ok = 0;
    in_opcode = op; in_dest = d; in_src1 = s1; in_src2 = s2; in_imm = imm;
    in_last = last; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) check("accept_timeout", 0, 1);
    else begin
      exp_q.push_back(model(op, d, s1, s2, imm));
      n_acc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    start = 1'b0;
    exp_addr = 0;
  endtask

  task automatic wait_done(input int wc);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (load_done) break;
    end
    check("load_done", load_done, 1);
    check("cpu_rst", cpu_rst, 0);
    check("word_count", word_count, wc);
    check("queue_drained", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_cpu_rst"}, cpu_rst, 1);
    check({tag, "_load_done"}, load_done, 0);
    check({tag, "_bad_op"}, bad_op, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_word_count"}, word_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; imem_wr_ready = 1'b1;
    in_opcode = '0; in_dest = '0; in_src1 = '0; in_src2 = '0; in_imm = '0;
    #3 rst = 1'b0;
    #9 check_reset_vals("rst");
    rst = 1'b1;
    @(posedge clk); #1;

    // IDLE does not accept bundles.
    in_valid = 1'b1;
    @(negedge clk);
    check("idle_in_ready", in_ready, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Single-instruction program.
    do_start();
    check("load_cpu_rst", cpu_rst, 1);
    send(`OP_ADD, 5'd3, 5'd1, 5'd2, 16'h0, 1'b1);
    wait_done(1);
    in_valid = 1'b1;
    @(negedge clk);
    check("post_last_in_ready", in_ready, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Immediate encodings.
    do_start();
    check("restart_load_done", load_done, 0);
    send(`OP_ADDI, 5'd4, 5'd1, 5'd0, 16'h00FF, 1'b0);
    send(`OP_LD,   5'd5, 5'd4, 5'd0, 16'h0008, 1'b0);
    send(`OP_ST,   5'd5, 5'd4, 5'd0, 16'h000C, 1'b1);
    wait_done(3);

    // Back-pressure: FIFO fills after 4 accepts, nothing written while stalled.
    do_start();
    imem_wr_ready = 1'b0;
    n_acc = 0;
    w0 = n_writes;
    fork
      begin
        for (int k = 0; k < 6; k++)
          send((k % 2 == 0) ? `OP_XOR : `OP_SUBI, 5'(k + 1), 5'(k + 7), 5'(k + 13),
               16'(16'h1000 + k), (k == 5));
      end
      begin
        repeat (10) @(negedge clk);
        check("bp_accepts", n_acc, 4);
        check("bp_in_ready", in_ready, 0);
        check("bp_writes", n_writes - w0, 0);
        check("bp_wr_en", wr_en, 1);
        check("bp_wr_addr", wr_addr, 0);
        @(posedge clk); #1;
        imem_wr_ready = 1'b1;
      end
    join
    wait_done(6);

    // Bad opcode in the middle.
    do_start();
    send(`OP_ADD, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
    send(6'h3F, 5'd7, 5'd7, 5'd7, 16'hFFFF, 1'b0);
    send(`OP_SUB, 5'd2, 5'd3, 5'd4, 16'h0, 1'b1);
    wait_done(3);
    check("bad_op_sticky", bad_op, 1);
    do_start();
    check("bad_op_cleared", bad_op, 0);

    // Address wrap on the 2-bit instance.
    do_start();
    send(`OP_AND,  5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
    send(`OP_BEZ,  5'd4, 5'd5, 5'd0, 16'h0040, 1'b0);
    send(`OP_SLL,  5'd6, 5'd7, 5'd8, 16'h0, 1'b0);
    send(`OP_JMP,  5'd0, 5'd0, 5'd0, 16'hBEEF, 1'b0);
    send(`OP_NOR,  5'd9, 5'd10, 5'd11, 16'h0, 1'b1);
    wait_done(5);
    check("wrap_overflow", w_overflow, 1);
    check("wrap_word_count", w_word_count, 5);
    check("wrap_load_done", w_load_done, 1);
    check("nowrap_overflow", overflow, 0);

    // Restart with two words still buffered.
    do_start();
    check("wrap_overflow_cleared", w_overflow, 0);
    imem_wr_ready = 1'b0;
    send(`OP_OR,  5'd1, 5'd1, 5'd1, 16'h0, 1'b0);
    send(`OP_BNE, 5'd2, 5'd2, 5'd0, 16'h0123, 1'b0);
    do_start();
    imem_wr_ready = 1'b1;
    send(`OP_SRA, 5'd12, 5'd13, 5'd14, 16'h0, 1'b1);
    wait_done(1);

    // Asynchronous reset mid-load.
    do_start();
    imem_wr_ready = 1'b0;
    send(6'h3E, 5'd1, 5'd1, 5'd1, 16'h0, 1'b0);
    send(`OP_SLA, 5'd3, 5'd4, 5'd5, 16'h0, 1'b0);
    check("pre_rst_bad_op", bad_op, 1);
    check("pre_rst_wr_en", wr_en, 1);
    #2 rst = 1'b0;
    #1 check_reset_vals("mid_rst");
    exp_q.delete();
    exp_addr = 0;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    imem_wr_ready = 1'b1;
    do_start();
    send(`OP_NOP, 5'd0, 5'd0, 5'd0, 16'h0, 1'b1);
    wait_done(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
